// File: rtl/filter_pkg.sv
// Shared definitions for the filter delivery path: packet field layout,
// packet type codes and the PE-side filter load state.
package filter_pkg;

  localparam int unsigned WIDTH_packet  = 57;
  localparam int unsigned WIDTH_payload = 40;
  localparam int unsigned WIDTH_data    = 8;
  localparam int unsigned FILTER_DIM    = 5;
  localparam int unsigned N_ENTRIES     = FILTER_DIM * FILTER_DIM;

  localparam int unsigned DEST_HI    = 56;
  localparam int unsigned DEST_LO    = 53;
  localparam int unsigned SRC_HI     = 52;
  localparam int unsigned SRC_LO     = 49;
  localparam int unsigned TYPE_HI    = 48;
  localparam int unsigned TYPE_LO    = 46;
  localparam int unsigned ROW_HI     = 45;
  localparam int unsigned ROW_LO     = 43;
  localparam int unsigned RSVD_HI    = 42;
  localparam int unsigned RSVD_LO    = 40;
  localparam int unsigned PAYLOAD_HI = 39;
  localparam int unsigned PAYLOAD_LO = 0;

  localparam logic [2:0] TYPE_FILTER = 3'b001;
  localparam logic [2:0] TYPE_IFMAP  = 3'b010;
  localparam logic [2:0] TYPE_PSUM   = 3'b011;

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} filt_state_t;

endpackage

// File: rtl/pe_filter_ingress_if.sv
// Packet ingress channel and registered filter read port between the PE and
// its filter receiver. master = PE/network side, slave = filter receiver.
interface pe_filter_ingress_if;
  import filter_pkg::*;

  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [WIDTH_packet-1:0] pkt_data;
  logic                    rd_en;
  logic [4:0]              rd_addr;
  logic [WIDTH_data-1:0]   rd_data;
  logic                    rd_valid;

  modport master (
    output pkt_valid, pkt_data, rd_en, rd_addr,
    input  pkt_ready, rd_data, rd_valid
  );

  modport slave (
    input  pkt_valid, pkt_data, rd_en, rd_addr,
    output pkt_ready, rd_data, rd_valid
  );

endinterface

// File: rtl/filter_regfile.sv
// 5x5 weight store: one full-row write port and a registered single read port
// with no write-to-read bypass.
module filter_regfile
  import filter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [2:0]               wr_row,
  input  logic [WIDTH_payload-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [4:0]               rd_addr,
  output logic [WIDTH_data-1:0]    rd_data,
  output logic                     rd_valid
);

  logic [WIDTH_data-1:0] mem_q [N_ENTRIES];
  logic [WIDTH_data-1:0] mem_d [N_ENTRIES];
  logic [WIDTH_data-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [4:0]            idx;

  always_comb begin
    mem_d      = mem_q;
    idx        = '0;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (wr_en) begin
      for (int unsigned k = 0; k < FILTER_DIM; k++) begin
        idx = 5'(int'(wr_row) * int'(FILTER_DIM) + int'(k));
        if (idx < 5'(N_ENTRIES)) mem_d[idx] = wr_data[WIDTH_data*k +: WIDTH_data];
      end
    end
    // Read sees pre-edge contents; out-of-range addresses return zero.
    if (rd_en) rd_data_d = (rd_addr < 5'(N_ENTRIES)) ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) mem_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/pe_filter_ingress.sv
// PE-side filter receiver: decodes filter row packets, tracks which rows are
// resident, and holds a complete filter until the PE releases it.
module pe_filter_ingress
  import filter_pkg::*;
#(
  parameter int unsigned NODE  = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pe_filter_ingress_if.slave    pkt,
  input  logic                  release_filter,
  output logic                  filter_loaded,
  output logic [ERR_W-1:0]      drop_count
);

  filt_state_t             state_q, state_d;
  logic [FILTER_DIM-1:0]   row_mask_q, row_mask_d;
  logic                    pkt_ready_q, pkt_ready_d;
  logic                    filter_loaded_q, filter_loaded_d;
  logic [ERR_W-1:0]        drop_count_q, drop_count_d;

  logic [3:0]              dest;
  logic [2:0]              ptype;
  logic [2:0]              row;
  logic                    accept, row_ok, wr_en;
  logic                    unused_fields;

  assign dest          = pkt.pkt_data[DEST_HI:DEST_LO];
  assign ptype         = pkt.pkt_data[TYPE_HI:TYPE_LO];
  assign row           = pkt.pkt_data[ROW_HI:ROW_LO];
  assign unused_fields = ^{pkt.pkt_data[SRC_HI:SRC_LO], pkt.pkt_data[RSVD_HI:RSVD_LO]};

  always_comb begin
    accept       = pkt.pkt_valid & pkt_ready_q;
    row_ok       = (dest == 4'(NODE)) && (ptype == TYPE_FILTER) && (row < 3'(FILTER_DIM));
    wr_en        = accept & row_ok;
    drop_count_d = drop_count_q;
    if (accept && !row_ok && (drop_count_q != '1)) drop_count_d = drop_count_q + ERR_W'(1);

    row_mask_d = row_mask_q;
    state_d    = state_q;
    unique case (state_q)
      EMPTY, LOADING: begin
        if (wr_en) begin
          row_mask_d[row] = 1'b1;
          state_d = (row_mask_d == '1) ? FULL : LOADING;
        end
      end
      FULL: begin
        // Entries are kept on release so stale weights stay readable.
        if (release_filter) begin
          state_d    = EMPTY;
          row_mask_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase

    pkt_ready_d     = (state_d != FULL);
    filter_loaded_d = (state_d == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= EMPTY;
      row_mask_q      <= '0;
      pkt_ready_q     <= 1'b0;
      filter_loaded_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      row_mask_q      <= row_mask_d;
      pkt_ready_q     <= pkt_ready_d;
      filter_loaded_q <= filter_loaded_d;
      drop_count_q    <= drop_count_d;
    end
  end

  filter_regfile u_regfile (
    .clk      (clk),
    .rst      (reset),
    .wr_en    (wr_en),
    .wr_row   (row),
    .wr_data  (pkt.pkt_data[PAYLOAD_HI:PAYLOAD_LO]),
    .rd_en    (pkt.rd_en),
    .rd_addr  (pkt.rd_addr),
    .rd_data  (pkt.rd_data),
    .rd_valid (pkt.rd_valid)
  );

  assign pkt.pkt_ready  = pkt_ready_q;
  assign filter_loaded  = filter_loaded_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_pe_filter_ingress.sv
// Bench for pe_filter_ingress: table vectors, directed corner sequences and
// random traffic compared against a behavioural filter-store model.
module tb_pe_filter_ingress;
  import filter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       release_filter;
  logic       filter_loaded;
  logic [7:0] drop_count;

  pe_filter_ingress_if bus();

  pe_filter_ingress #(.NODE(1), .ERR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .pkt            (bus),
    .release_filter (release_filter),
    .filter_loaded  (filter_loaded),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: weights, which rows have arrived, full flag, drops.
  byte unsigned m_mem [25];
  bit           m_have [5];
  bit           m_full, m_ready, m_rd_valid;
  int unsigned  m_drops;
  byte unsigned m_rd_data;

  typedef struct {
    logic [3:0]  dest;
    logic [2:0]  typ;
    logic [2:0]  row;
    logic [7:0]  fill;
    logic        exp_loaded;
    int unsigned exp_drops;
  } vec_t;
  vec_t tbl [8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 25; i++) m_mem[i] = 0;
    for (int r = 0; r < 5; r++) m_have[r] = 0;
    m_full = 0; m_ready = 0; m_drops = 0; m_rd_valid = 0; m_rd_data = 0;
  endfunction

  function automatic void model_edge();
    byte unsigned old [25];
    int unsigned  dest, typ, row;
    bit           all;
    old  = m_mem;
    dest = int'(bus.pkt_data[56:53]);
    typ  = int'(bus.pkt_data[48:46]);
    row  = int'(bus.pkt_data[45:43]);
    if (bus.pkt_valid && m_ready) begin
      if (dest != 1 || typ != 1 || row > 4) begin
        if (m_drops < 255) m_drops++;
      end else begin
        for (int k = 0; k < 5; k++) m_mem[row*5 + k] = bus.pkt_data[8*k +: 8];
        m_have[row] = 1;
      end
    end
    if (bus.rd_en) begin
      m_rd_valid = 1;
      m_rd_data  = (bus.rd_addr < 25) ? old[bus.rd_addr] : 8'd0;
    end else begin
      m_rd_valid = 0;
    end
    if (m_full && release_filter) begin
      m_full = 0;
      for (int r = 0; r < 5; r++) m_have[r] = 0;
    end else if (!m_full) begin
      all = 1;
      for (int r = 0; r < 5; r++) if (!m_have[r]) all = 0;
      m_full = all;
    end
    m_ready = !m_full;
  endfunction

  function automatic void compare_all();
    chk("pkt_ready",     32'(bus.pkt_ready), 32'(m_ready));
    chk("filter_loaded", 32'(filter_loaded), 32'(m_full));
    chk("drop_count",    32'(drop_count),    m_drops);
    chk("rd_valid",      32'(bus.rd_valid),  32'(m_rd_valid));
    chk("rd_data",       32'(bus.rd_data),   32'(m_rd_data));
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [56:0] mkpkt(logic [3:0] dest, logic [2:0] typ,
                                        logic [2:0] row, logic [39:0] payload);
    logic [56:0] p;
    p = '0;
    p[56:53] = dest;
    p[52:49] = 4'h3;
    p[48:46] = typ;
    p[45:43] = row;
    p[39:0]  = payload;
    return p;
  endfunction

  function automatic logic [39:0] seq_pay(int base);
    logic [39:0] p;
    for (int k = 0; k < 5; k++) p[8*k +: 8] = 8'(base + k);
    return p;
  endfunction

  function automatic logic [39:0] fill_pay(logic [7:0] b);
    return {5{b}};
  endfunction

  task automatic send(logic [3:0] dest, logic [2:0] typ, logic [2:0] row, logic [39:0] payload);
    bus.pkt_data  = mkpkt(dest, typ, row, payload);
    bus.pkt_valid = 1'b1;
    cyc();
    bus.pkt_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rd_chk(string name, int addr, logic [7:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'(addr);
    cyc();
    bus.rd_en   = 1'b0;
    chk(name, 32'(bus.rd_data), 32'(exp));
    chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
  endtask

  task automatic release_now();
    release_filter = 1'b1;
    cyc();
    release_filter = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; release_filter = 1'b0;
    bus.pkt_valid = 1'b0; bus.pkt_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    model_reset();

    tbl[0] = '{4'd1, 3'b001, 3'd0, 8'h00, 1'b0, 0};
    tbl[1] = '{4'd2, 3'b001, 3'd0, 8'hEE, 1'b0, 1};
    tbl[2] = '{4'd1, 3'b001, 3'd1, 8'h00, 1'b0, 1};
    tbl[3] = '{4'd1, 3'b010, 3'd1, 8'hEE, 1'b0, 2};
    tbl[4] = '{4'd1, 3'b001, 3'd2, 8'h00, 1'b0, 2};
    tbl[5] = '{4'd1, 3'b001, 3'd6, 8'hEE, 1'b0, 3};
    tbl[6] = '{4'd1, 3'b001, 3'd3, 8'h00, 1'b0, 3};
    tbl[7] = '{4'd1, 3'b001, 3'd4, 8'h00, 1'b1, 3};

    #1;
    do_reset();
    chk("reset_loaded", 32'(filter_loaded), 32'd0);
    idle(1);
    chk("ready_after_reset", 32'(bus.pkt_ready), 32'd1);

    // Test 1: in-order load, then read everything back.
    for (int r = 0; r < 5; r++) begin
      send(4'd1, TYPE_FILTER, 3'(r), seq_pay(r*5));
      chk("t1_loaded", 32'(filter_loaded), 32'(r == 4));
      chk("t1_ready",  32'(bus.pkt_ready), 32'(r != 4));
    end
    for (int a = 0; a < 25; a++) rd_chk("t1_rd", a, 8'(a));
    rd_chk("t1_rd_oob25", 25, 8'd0);
    rd_chk("t1_rd_oob31", 31, 8'd0);
    release_now();

    // Test 2: out-of-order rows with gaps.
    begin
      int order [5] = '{3, 1, 4, 0, 2};
      for (int i = 0; i < 5; i++) begin
        send(4'd1, TYPE_FILTER, 3'(order[i]), seq_pay(order[i]*5 + 50));
        chk("t2_loaded", 32'(filter_loaded), 32'(i == 4));
        idle(2);
      end
    end
    for (int a = 0; a < 25; a++) rd_chk("t2_rd", a, 8'(a + 50));
    release_now();

    // Test 3: duplicate row 2 must not complete the filter early.
    for (int r = 0; r < 4; r++) send(4'd1, TYPE_FILTER, 3'(r), seq_pay(r*5));
    send(4'd1, TYPE_FILTER, 3'd2, fill_pay(8'hAA));
    chk("t3_dup_not_loaded", 32'(filter_loaded), 32'd0);
    send(4'd1, TYPE_FILTER, 3'd4, seq_pay(20));
    chk("t3_loaded", 32'(filter_loaded), 32'd1);
    for (int a = 10; a < 15; a++) rd_chk("t3_rd_aa", a, 8'hAA);
    rd_chk("t3_rd9", 9, 8'd9);
    rd_chk("t3_rd15", 15, 8'd15);
    release_now();

    // Test 4: table with interleaved drops.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].dest, tbl[i].typ, tbl[i].row,
           (tbl[i].fill == 8'hEE) ? fill_pay(8'hEE) : seq_pay(int'(tbl[i].row)*5));
      chk("t4_loaded", 32'(filter_loaded), 32'(tbl[i].exp_loaded));
      chk("t4_drops",  32'(drop_count),    tbl[i].exp_drops);
    end
    for (int a = 0; a < 25; a++) rd_chk("t4_rd", a, 8'(a));

    // Test 5: FULL blocks packets; release and reload.
    bus.pkt_data  = mkpkt(4'd1, TYPE_FILTER, 3'd0, fill_pay(8'hFF));
    bus.pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_blocked", 32'(bus.pkt_ready), 32'd0);
    end
    bus.pkt_valid = 1'b0;
    rd_chk("t5_unchanged", 0, 8'd0);
    release_now();
    chk("t5_rel_loaded", 32'(filter_loaded), 32'd0);
    chk("t5_rel_ready",  32'(bus.pkt_ready), 32'd1);
    rd_chk("t5_stale", 7, 8'd7);
    for (int r = 0; r < 5; r++) send(4'd1, TYPE_FILTER, 3'(r), fill_pay(8'hFF));
    chk("t5_loaded", 32'(filter_loaded), 32'd1);
    for (int a = 0; a < 25; a++) rd_chk("t5_rd", a, 8'hFF);
    release_now();

    // Test 6: reset mid-load discards everything.
    for (int r = 0; r < 3; r++) send(4'd1, TYPE_FILTER, 3'(r), seq_pay(r*5 + 100));
    do_reset();
    chk("t6_loaded", 32'(filter_loaded), 32'd0);
    chk("t6_drops",  32'(drop_count),    32'd0);
    idle(1);
    for (int a = 0; a < 25; a++) rd_chk("t6_rd_zero", a, 8'd0);
    for (int r = 0; r < 5; r++) send(4'd1, TYPE_FILTER, 3'(r), seq_pay(r*5));
    chk("t6_loaded_after", 32'(filter_loaded), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.pkt_valid  = 1'($urandom_range(0, 1));
      bus.pkt_data   = mkpkt(($urandom_range(0, 7) == 0) ? 4'd2 : 4'd1,
                             ($urandom_range(0, 7) == 0) ? TYPE_IFMAP : TYPE_FILTER,
                             3'($urandom_range(0, 5)),
                             {8'($urandom), 32'($urandom)});
      bus.rd_en      = 1'($urandom_range(0, 1));
      bus.rd_addr    = 5'($urandom_range(0, 31));
      release_filter = ($urandom_range(0, 3) == 0);
      cyc();
    end
    bus.pkt_valid = 1'b0; bus.rd_en = 1'b0; release_filter = 1'b0;
    idle(1);

    // Drop counter saturation.
    if (m_full) release_now();
    for (int i = 0; i < 270; i++) send(4'd5, TYPE_FILTER, 3'd0, fill_pay(8'h11));
    chk("sat_drops", 32'(drop_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_filter_ingress.md
Name: pe_filter_ingress

Overview:
- Clocked receiver at the PE side of the filter path; consumes the 57-bit packets that filter_mem_node emits toward a PE.
- Decodes each packet and unpacks its five 8-bit weights into a 5x5 filter register file.
- Signals when a full filter is resident and serves registered reads to the PE MAC datapath.
- Holds the filter until the PE releases it, then accepts a reload.

Parameters:
NODE, 1, this PE's node id; packets with any other dest are dropped
WIDTH_packet, 57, packet width
WIDTH_payload, 40, payload width (5 weights x 8 bits)
WIDTH_data, 8, weight width
FILTER_DIM, 5, filter rows/cols; 25 entries total
TYPE_FILTER, 3'b001, packet type code for filter rows
ERR_W, 8, width of drop counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pkt_valid  in  1  packet present on pkt_data
pkt_ready  out  1  block can accept a packet this cycle
pkt_data  in  57  packet: [56:53] dest, [52:49] src, [48:46] type, [45:43] row, [42:40] reserved, [39:0] payload
rd_en  in  1  read request
rd_addr  in  5  read index, row*5+col, 0..24
rd_data  out  8  weight, valid the cycle after rd_en
rd_valid  out  1  rd_data qualifier
filter_loaded  out  1  all 5 rows resident
release_filter  in  1  PE finished with the filter; enables reload
drop_count  out  ERR_W  number of rejected packets, saturating

Behaviour:
- Reset, asynchronous, active-high:
  - state=EMPTY, row_mask=0, all 25 entries=0.
  - rd_data=0, rd_valid=0, filter_loaded=0, drop_count=0.
  - pkt_ready=1 one clock after reset deasserts; it is 0 while reset is high.
- Transfer: a packet is accepted on a rising edge with pkt_valid&pkt_ready. pkt_ready is registered-state derived: 1 in EMPTY/LOADING, 0 in FULL.
- Payload unpacking: byte k = payload[8k+7:8k] goes to entry row*5+k for k=0..4.
- Accept checks, in priority order, for every accepted packet:
  - dest!=NODE -> drop.
  - type!=TYPE_FILTER -> drop.
  - row>4 -> drop.
  - A drop increments drop_count (saturating at all-ones) and writes no entries.
  - Otherwise, on the same edge, write the 5 entries and set row_mask[row].
- Duplicate row while LOADING: overwrite the entries; row_mask is unchanged and the row is not double-counted.
- State machine:
  - EMPTY -> LOADING on the first valid row write.
  - LOADING -> FULL on the edge where row_mask becomes 5'b11111.
  - FULL -> EMPTY on release_filter=1; row_mask clears and entries are retained.
  - release_filter in EMPTY or LOADING is ignored.
- filter_loaded = (state==FULL). It is registered, so it asserts the cycle after the last row is accepted.
- pkt_ready drops in that same cycle, so no packet is accepted in FULL.
- Reads:
  - rd_en at edge N -> rd_data=entry[rd_addr] and rd_valid=1 after edge N+1; 1-cycle latency.
  - rd_en=0 -> rd_valid=0 and rd_data holds its last value.
  - rd_addr>24 -> rd_data=0 with rd_valid=1.
  - Reads are allowed in any state and return current contents.
  - A read of an entry written on the same edge returns the old value; no bypass.
- Reset mid-load: all state is discarded and no partial filter is reported.
- Release and reload: after release, a new load overwrites rows; stale entries of rows not yet rewritten stay readable but filter_loaded=0.

Decomposition:
- Shared package filter_pkg holds:
  - packet field position localparams (DEST_HI/LO, SRC_HI/LO, TYPE_HI/LO, ROW_HI/LO, PAYLOAD_HI/LO);
  - packet type codes (TYPE_FILTER, TYPE_IFMAP, TYPE_PSUM);
  - typedef enum logic [1:0] {EMPTY, LOADING, FULL} filt_state_t;
  - FILTER_DIM.
- One sub-module: filter_regfile, a 25x8 register array with a 5-wide row write port and a registered single read port. The packet decode and state machine stay in pe_filter_ingress.

Test Plan:
1. Reset, then send rows 0..4 to dest=1, type=001, payload bytes row*5+k (0..24), one per cycle -> filter_loaded=1 the cycle after row 4; pkt_ready=0; reads of addr 0..24 return 0..24, each 1 cycle after rd_en.
2. Send rows in order 3,1,4,0,2 with pkt_valid gaps -> filter_loaded asserts only after row 2; contents are correct.
3. Rows 0..3, then a row 2 repeat with bytes 8'hAA, then row 4 -> loaded after row 4; addr 10..14 read 8'hAA; row_mask is not double-counted.
4. Packets with dest=2, type=010 and row=6 interleaved with a valid load -> drop_count=3; those packets write no entries; the load completes normally.
5. In FULL, hold pkt_valid=1 -> nothing is accepted; assert release_filter for 1 cycle -> filter_loaded=0, pkt_ready=1 next cycle; reload with 8'hFF -> all reads return 8'hFF.
6. Assert reset after 3 rows accepted -> filter_loaded=0, drop_count=0, all reads return 0; a subsequent 5-row load completes.
